// File: rtl/l4_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : l4_scan_pkg
//  Brief    : Shared state encoding and default geometry for the layer scanner
//  Revision : 1.0
// ============================================================================
package l4_scan_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BLANK = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      ON    = 3'd4
   } scan_state_e;

   // Default geometry: 8 layers of 32 columns.
   localparam int unsigned c_NLBITS    = 3;
   localparam int unsigned c_NLAYERS   = 8;
   localparam int unsigned c_NCBITS    = 5;
   localparam int unsigned c_NCOLS     = 32;
   localparam int unsigned c_BLANK_CYC = 2;
   localparam int unsigned c_CNTW      = 16;

endpackage : l4_scan_pkg
`default_nettype wire

// File: rtl/l4_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module   : l4_dwell_timer
//  Brief    : Loadable down-counter; done flags the last cycle of an interval
//  Revision : 1.0
// ============================================================================
module l4_dwell_timer #(
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_load,
   input  logic [CNTW-1:0] i_value,
   output logic            o_done
);

   logic [CNTW-1:0] r_cnt;

   // A loaded value N yields N cycles; done is high during the last one.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == CNTW'(1));

endmodule : l4_dwell_timer
`default_nettype wire

// File: rtl/l4_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : l4_scan_ctrl
//  Brief    : Layer scan sequencer (blank, shift, latch, dwell) with
//             frame-boundary display-buffer swapping
//  Revision : 1.0
// ============================================================================
module l4_scan_ctrl
   import l4_scan_pkg::*;
#(
   parameter int NLBITS    = c_NLBITS,
   parameter int NLAYERS   = c_NLAYERS,
   parameter int NCBITS    = c_NCBITS,
   parameter int NCOLS     = c_NCOLS,
   parameter int BLANK_CYC = c_BLANK_CYC,
   parameter int CNTW      = c_CNTW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [CNTW-1:0]   on_cycles,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              bank,
   output logic [NLBITS-1:0] layer,
   output logic [NCBITS-1:0] col_idx,
   output logic              shift_en,
   output logic              latch,
   output logic              oe,
   output logic              frame_start
);

   localparam logic [NLBITS-1:0] c_LAST_LAYER = NLBITS'(NLAYERS - 1);

   scan_state_e       r_state;
   scan_state_e       w_state_nxt;
   logic [NLBITS-1:0] r_layer;
   logic [NLBITS-1:0] w_layer_nxt;
   logic [NCBITS-1:0] r_col_idx;
   logic [NCBITS-1:0] w_col_nxt;
   logic              r_bank;
   logic              w_bank_nxt;
   logic              r_swap_ack;
   logic              w_swap_ack_nxt;
   logic              r_frame_start;
   logic              w_frame_start_nxt;
   logic              r_oe;
   logic              r_shift_en;
   logic              r_latch;
   logic              w_advance;
   logic              w_swap_ok;
   logic              w_tmr_load;
   logic [CNTW-1:0]   w_tmr_val;
   logic              w_tmr_done;

   // Guard keeps acks at least one cycle apart even with swap_req held.
   assign w_swap_ok = swap_req & ~r_swap_ack;

   l4_dwell_timer #(
      .CNTW (CNTW)
   ) u_dwell_timer (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_val),
      .o_done  (w_tmr_done)
   );

   always_comb begin
      w_state_nxt       = r_state;
      w_layer_nxt       = r_layer;
      w_col_nxt         = r_col_idx;
      w_bank_nxt        = r_bank;
      w_swap_ack_nxt    = 1'b0;
      w_frame_start_nxt = 1'b0;
      w_advance         = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_swap_ok) begin
               w_bank_nxt     = ~r_bank;
               w_swap_ack_nxt = 1'b1;
            end
            if (run) begin
               w_state_nxt       = BLANK;
               w_layer_nxt       = '0;
               w_frame_start_nxt = 1'b1;
            end
         end
         BLANK: begin
            if (w_tmr_done) begin
               w_state_nxt = SHIFT;
               w_col_nxt   = '0;
            end
         end
         SHIFT: begin
            if (w_tmr_done) begin
               w_state_nxt = LATCH;
               w_col_nxt   = '0;
            end else begin
               w_col_nxt = r_col_idx + 1'b1;
            end
         end
         LATCH: begin
            if (on_cycles != '0) begin
               w_state_nxt = ON;
            end else begin
               w_advance = 1'b1;
            end
         end
         ON: begin
            if (w_tmr_done) begin
               w_advance = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Layer advance; the frame wrap is the only point where run and
      // swap_req are honoured outside IDLE, so a frame is never torn.
      if (w_advance) begin
         if (r_layer != c_LAST_LAYER) begin
            w_layer_nxt = r_layer + 1'b1;
            w_state_nxt = BLANK;
         end else begin
            w_layer_nxt = '0;
            if (w_swap_ok) begin
               w_bank_nxt     = ~r_bank;
               w_swap_ack_nxt = 1'b1;
            end
            if (run) begin
               w_state_nxt       = BLANK;
               w_frame_start_nxt = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
      end
   end

   // Every state change reloads the timer with the new state's interval.
   always_comb begin
      w_tmr_load = (w_state_nxt != r_state);
      case (w_state_nxt)
         BLANK:   w_tmr_val = CNTW'(BLANK_CYC);
         SHIFT:   w_tmr_val = CNTW'(NCOLS);
         ON:      w_tmr_val = on_cycles;
         default: w_tmr_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_layer       <= '0;
         r_col_idx     <= '0;
         r_bank        <= 1'b0;
         r_swap_ack    <= 1'b0;
         r_frame_start <= 1'b0;
         r_oe          <= 1'b0;
         r_shift_en    <= 1'b0;
         r_latch       <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_layer       <= w_layer_nxt;
         r_col_idx     <= w_col_nxt;
         r_bank        <= w_bank_nxt;
         r_swap_ack    <= w_swap_ack_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_oe          <= (w_state_nxt == ON);
         r_shift_en    <= (w_state_nxt == SHIFT);
         r_latch       <= (w_state_nxt == LATCH);
      end
   end

   assign swap_ack    = r_swap_ack;
   assign bank        = r_bank;
   assign layer       = r_layer;
   assign col_idx     = r_col_idx;
   assign shift_en    = r_shift_en;
   assign latch       = r_latch;
   assign oe          = r_oe;
   assign frame_start = r_frame_start;

endmodule : l4_scan_ctrl
`default_nettype wire

// File: tb/tb_l4_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l4_scan_ctrl
//  Brief    : Directed scenarios plus random traffic against a cycle-position
//             reference model of the layer scanner
//  Revision : 1.0
// ============================================================================
module tb_l4_scan_ctrl;

   localparam int c_NLBITS  = 2;
   localparam int c_NLAYERS = 4;
   localparam int c_NCBITS  = 2;
   localparam int c_NCOLS   = 4;
   localparam int c_BLANK   = 2;
   localparam int c_CNTW    = 8;

   logic                r_clk = 1'b0;
   logic                r_reset;
   logic                r_run;
   logic [c_CNTW-1:0]   r_on_cycles;
   logic                r_swap_req;
   logic                w_swap_ack;
   logic                w_bank;
   logic [c_NLBITS-1:0] w_layer;
   logic [c_NCBITS-1:0] w_col_idx;
   logic                w_shift_en;
   logic                w_latch;
   logic                w_oe;
   logic                w_frame_start;

   int n_total = 0;
   int n_bad   = 0;

   always #5 r_clk = ~r_clk;

   l4_scan_ctrl #(
      .NLBITS    (c_NLBITS),
      .NLAYERS   (c_NLAYERS),
      .NCBITS    (c_NCBITS),
      .NCOLS     (c_NCOLS),
      .BLANK_CYC (c_BLANK),
      .CNTW      (c_CNTW)
   ) u_dut (
      .clk         (r_clk),
      .reset       (r_reset),
      .run         (r_run),
      .on_cycles   (r_on_cycles),
      .swap_req    (r_swap_req),
      .swap_ack    (w_swap_ack),
      .bank        (w_bank),
      .layer       (w_layer),
      .col_idx     (w_col_idx),
      .shift_en    (w_shift_en),
      .latch       (w_latch),
      .oe          (w_oe),
      .frame_start (w_frame_start)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Reference model: a layer is a run of cycles indexed by position k.
   // k<B blank, B<=k<B+N shift column k-B, k==B+N latch (dwell sampled),
   // then dwell cycles of oe; the layer ends at k==B+N+dwell.
   bit m_valid  = 1'b0;
   bit m_active = 1'b0;
   bit m_bank   = 1'b0;
   bit m_ack    = 1'b0;
   bit m_fs     = 1'b0;
   int m_layer  = 0;
   int m_k      = 0;
   int m_d      = 0;

   always @(posedge r_clk) begin
      bit ack_n;
      bit fs_n;
      ack_n = 1'b0;
      fs_n  = 1'b0;
      if (r_reset) begin
         m_active = 1'b0;
         m_layer  = 0;
         m_k      = 0;
         m_d      = 0;
         m_bank   = 1'b0;
         m_valid  = 1'b1;
      end else if (!m_active) begin
         if (r_swap_req && !m_ack) begin
            m_bank = !m_bank;
            ack_n  = 1'b1;
         end
         if (r_run) begin
            m_active = 1'b1;
            m_layer  = 0;
            m_k      = 0;
            fs_n     = 1'b1;
         end
      end else begin
         if (m_k == c_BLANK + c_NCOLS) m_d = int'(r_on_cycles);
         if (m_k == c_BLANK + c_NCOLS + m_d) begin
            m_k = 0;
            if (m_layer < c_NLAYERS - 1) begin
               m_layer++;
            end else begin
               m_layer = 0;
               if (r_swap_req && !m_ack) begin
                  m_bank = !m_bank;
                  ack_n  = 1'b1;
               end
               if (r_run) fs_n = 1'b1;
               else m_active = 1'b0;
            end
         end else begin
            m_k++;
         end
      end
      m_ack = ack_n;
      m_fs  = fs_n;
   end

   // Per-cycle scoreboard and invariants, sampled mid-cycle.
   logic [c_NLBITS-1:0] p_layer = '0;
   always @(negedge r_clk) begin
      if (m_valid) begin
         bit e_shift, e_latch, e_oe;
         int e_col;
         e_shift = m_active && (m_k >= c_BLANK) && (m_k < c_BLANK + c_NCOLS);
         e_latch = m_active && (m_k == c_BLANK + c_NCOLS);
         e_oe    = m_active && (m_k > c_BLANK + c_NCOLS) && (m_k <= c_BLANK + c_NCOLS + m_d);
         e_col   = e_shift ? (m_k - c_BLANK) : 0;
         chk("outs",
             32'({w_frame_start, w_swap_ack, w_bank, w_layer, w_col_idx, w_shift_en, w_latch, w_oe}),
             32'({m_fs, m_ack, m_bank, c_NLBITS'(m_layer), c_NCBITS'(e_col), e_shift, e_latch, e_oe}));
         chk("mutex", 32'($countones({w_oe, w_shift_en, w_latch}) <= 1), 32'd1);
         if (w_layer != p_layer) chk("layer_chg_oe", 32'(w_oe), 32'd0);
         p_layer = w_layer;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int oe_cnt;
      int sh_cnt;
      int fs_cnt;

      r_reset = 1'b1; r_run = 1'b0; r_swap_req = 1'b0; r_on_cycles = 8'd5;
      repeat (3) @(negedge r_clk);
      chk("rst_oe",   32'(w_oe), 0);
      chk("rst_sh",   32'(w_shift_en), 0);
      chk("rst_lat",  32'(w_latch), 0);
      chk("rst_fs",   32'(w_frame_start), 0);
      chk("rst_bank", 32'(w_bank), 0);
      chk("rst_lay",  32'(w_layer), 0);

      // Basic frame with a swap request and a dwell change during ON.
      r_reset = 1'b0; r_run = 1'b1;
      for (int c = 0; c <= 50; c++) begin
         if (c == 0 || c == 2)  chk("fs_lo", 32'(w_frame_start), 0);
         if (c == 1)            chk("fs_c1", 32'(w_frame_start), 1);
         if (c >= 3 && c <= 6)  chk("shift_col", 32'({w_shift_en, w_col_idx}), 32'({1'b1, 2'(c - 3)}));
         if (c == 7)            chk("latch_c7", 32'({w_latch, w_shift_en, w_col_idx}), 32'({1'b1, 1'b0, 2'd0}));
         if (c >= 8 && c <= 12) chk("oe_on", 32'(w_oe), 1);
         if (c == 13)           chk("c13", 32'({w_oe, w_layer}), 32'({1'b0, 2'd1}));
         if (c == 48)           chk("c48", 32'({w_bank, w_swap_ack, w_oe, w_layer}), 32'({1'b0, 1'b0, 1'b1, 2'd3}));
         if (c == 49)           chk("c49", 32'({w_bank, w_swap_ack, w_frame_start, w_layer}), 32'({1'b1, 1'b1, 1'b1, 2'd0}));
         if (c == 50)           chk("c50", 32'({w_bank, w_swap_ack}), 32'({1'b1, 1'b0}));
         if (c == 9)  r_on_cycles = 8'd2;
         if (c == 11) r_on_cycles = 8'd5;
         if (c == 20) r_swap_req  = 1'b1;
         if (w_swap_ack) r_swap_req = 1'b0;
         @(negedge r_clk);
      end

      // Zero dwell: 7-cycle layers, 28-cycle frames, oe never high.
      r_on_cycles = 8'd0;
      n = 0;
      while (!w_frame_start && n < 200) begin @(negedge r_clk); n++; end
      chk("fs_wait0", 32'(w_frame_start), 1);
      n = 0; oe_cnt = 0;
      do begin
         if (w_oe) oe_cnt++;
         @(negedge r_clk); n++;
      end while (!w_frame_start && n < 200);
      chk("zero_frame_len", 32'(n), 28);
      chk("zero_oe_cnt", 32'(oe_cnt), 0);
      r_on_cycles = 8'd5;

      // Stop during layer 1: the frame finishes, then the scanner idles.
      n = 0;
      while (w_layer != 2'd1 && n < 200) begin @(negedge r_clk); n++; end
      chk("wait_layer1", 32'(w_layer), 1);
      r_run = 1'b0;
      oe_cnt = 0; sh_cnt = 0; fs_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (w_oe) oe_cnt++;
         if (w_shift_en) sh_cnt++;
         if (w_frame_start) fs_cnt++;
         @(negedge r_clk);
      end
      chk("stop_oe_cnt", 32'(oe_cnt), 15);
      chk("stop_sh_cnt", 32'(sh_cnt), 12);
      chk("stop_fs_cnt", 32'(fs_cnt), 0);
      chk("stop_idle", 32'({w_layer, w_oe, w_shift_en, w_latch}), 0);
      r_run = 1'b1;
      @(negedge r_clk);
      chk("restart_fs", 32'(w_frame_start), 1);

      // Reset during layer 2 ON (bank is 1 from the earlier swap).
      n = 0;
      while (!(w_layer == 2'd2 && w_oe) && n < 200) begin @(negedge r_clk); n++; end
      chk("wait_l2_on", 32'({w_layer, w_oe}), 32'({2'd2, 1'b1}));
      r_reset = 1'b1;
      @(negedge r_clk);
      chk("midrst", 32'({w_oe, w_layer, w_bank, w_shift_en, w_latch, w_col_idx, w_frame_start}), 0);
      r_reset = 1'b0; r_run = 1'b0;
      repeat (2) @(negedge r_clk);
      chk("idle_quiet", 32'({w_frame_start, w_oe, w_shift_en}), 0);

      // Swap while idle.
      r_swap_req = 1'b1;
      @(negedge r_clk);
      chk("idle_ack", 32'({w_swap_ack, w_bank}), 32'({1'b1, 1'b1}));
      r_swap_req = 1'b0;
      @(negedge r_clk);
      chk("idle_ack_off", 32'({w_swap_ack, w_bank}), 32'({1'b0, 1'b1}));

      // Random traffic, checked every cycle by the scoreboard.
      for (int i = 0; i < 3000; i++) begin
         if (w_swap_ack) r_swap_req = 1'b0;
         else if (!r_swap_req && $urandom_range(0, 29) == 0) r_swap_req = 1'b1;
         if ($urandom_range(0, 39) == 0) r_run = !r_run;
         if ($urandom_range(0, 2) == 0) r_on_cycles = 8'($urandom_range(0, 6));
         r_reset = ($urandom_range(0, 499) == 0);
         @(negedge r_clk);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_l4_scan_ctrl
`default_nettype wire
